// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin denominations, coin index type, dispenser states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vending_pkg;

    localparam int NUM_COINS = 5;

    // Index 0..4 selects a denomination; wider than needed so 5..7 can be rejected explicitly.
    typedef logic [2:0] coin_idx_t;

    localparam coin_idx_t LAST_COIN_IDX = coin_idx_t'(NUM_COINS - 1);

    // Coin values in ascending order, indexed by coin_idx_t.
    localparam logic [7:0] COIN_VALUE [NUM_COINS] = '{8'd10, 8'd20, 8'd50, 8'd100, 8'd200};

    typedef enum logic [1:0] {
        DS_IDLE     = 2'd0,
        DS_SELECT   = 2'd1,
        DS_DISPENSE = 2'd2,
        DS_DONE     = 2'd3
    } disp_state_t;

    // Value of a denomination; out-of-range indices map to 0.
    function automatic logic [7:0] coin_value(input coin_idx_t idx);
        logic [7:0] v;
        case (idx)
            3'd0:    v = COIN_VALUE[0];
            3'd1:    v = COIN_VALUE[1];
            3'd2:    v = COIN_VALUE[2];
            3'd3:    v = COIN_VALUE[3];
            3'd4:    v = COIN_VALUE[4];
            default: v = 8'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/coin_selector.sv
// Greedy pick of the largest stocked denomination not exceeding the remaining amount.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only while the dispenser is selecting.
module coin_selector
    import vending_pkg::*;
(
    input  logic [7:0]           remaining,
    input  logic [NUM_COINS-1:0] avail,
    output logic                 found,
    output coin_idx_t            idx
);

    // Ascending scan: the last qualifying denomination wins, which is the largest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (avail[i] && (COIN_VALUE[i] <= remaining)) begin
                found = 1'b1;
                idx   = coin_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout: accepts an amount, ejects coins greedily one per handshake, reports shortfall.
// Latency: first coin 1 cycle after acceptance; one coin per 2 cycles with ack held high; done 1 cycle after last ack.
// Backpressure: change_ready only in IDLE; a coin is held stable on coin_out until coin_ack.
// Optional build macro CHANGE_DISPENSER_STATS_EN adds coins_total / shortfall_events counters.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int INV_W      = 4,
    parameter int INIT_COUNT = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  change_in,
    input  logic        change_valid,
    output logic        change_ready,
    output logic [7:0]  coin_out,
    output logic        coin_valid,
    input  logic        coin_ack,
    input  logic        refill_valid,
    input  logic [2:0]  refill_idx,
    output logic        busy,
    output logic        done,
`ifdef CHANGE_DISPENSER_STATS_EN
    output logic [15:0] coins_total,
    output logic [7:0]  shortfall_events,
`endif
    output logic [7:0]  shortfall
);

    localparam logic [1:0] S_IDLE     = DS_IDLE;
    localparam logic [1:0] S_SELECT   = DS_SELECT;
    localparam logic [1:0] S_DISPENSE = DS_DISPENSE;
    localparam logic [1:0] S_DONE     = DS_DONE;

    localparam logic [INV_W-1:0] INV_MAX  = '1;
    localparam logic [INV_W-1:0] INV_INIT = INV_W'(INIT_COUNT);

    logic [1:0]             state;
    logic [7:0]             remaining;
    coin_idx_t              sel_idx;
    logic [INV_W-1:0]       inv [NUM_COINS];

    logic [NUM_COINS-1:0]   avail;
    logic [NUM_COINS-1:0]   inv_inc;
    logic [NUM_COINS-1:0]   inv_dec;
    logic                   pick_found;
    coin_idx_t              pick_idx;
    logic                   ack_take;
    logic                   refill_hit;

    assign change_ready = (state == S_IDLE);
    assign coin_valid   = (state == S_DISPENSE);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);

    // An ack only counts while a coin is actually presented.
    assign ack_take   = coin_valid && coin_ack;
    assign refill_hit = refill_valid && (refill_idx <= LAST_COIN_IDX);

    coin_selector u_coin_selector (
        .remaining (remaining),
        .avail     (avail),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // Per-denomination stock flags and the increment/decrement requests for this cycle.
    always_comb begin
        avail   = '0;
        inv_inc = '0;
        inv_dec = '0;
        for (int d = 0; d < NUM_COINS; d++) begin
            avail[d]   = (inv[d] != '0);
            inv_inc[d] = refill_hit && (refill_idx == coin_idx_t'(d));
            inv_dec[d] = ack_take && (sel_idx == coin_idx_t'(d));
        end
    end

    // Payout sequencer: latch amount, pick a coin, wait for its ack, repeat, then report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            coin_out  <= '0;
            sel_idx   <= '0;
            shortfall <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (change_valid) begin
                        remaining <= change_in;
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (pick_found && (remaining != 8'd0)) begin
                        coin_out <= coin_value(pick_idx);
                        sel_idx  <= pick_idx;
                        state    <= S_DISPENSE;
                    end else begin
                        shortfall <= remaining;
                        state     <= S_DONE;
                    end
                end
                S_DISPENSE: begin
                    // Selection guaranteed coin_out <= remaining, so no underflow here.
                    if (coin_ack) begin
                        remaining <= remaining - coin_out;
                        coin_out  <= '0;
                        state     <= S_SELECT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Inventory counters: saturating refill, decrement on ack, simultaneous hit cancels out.
    always_ff @(posedge clk) begin
        for (int d = 0; d < NUM_COINS; d++) begin
            if (rst) begin
                inv[d] <= INV_INIT;
            end else if (inv_inc[d] && !inv_dec[d]) begin
                if (inv[d] != INV_MAX) begin
                    inv[d] <= inv[d] + 1'b1;
                end
            end else if (inv_dec[d] && !inv_inc[d]) begin
                inv[d] <= inv[d] - 1'b1;
            end
        end
    end

`ifdef CHANGE_DISPENSER_STATS_EN
    // Saturating usage counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            coins_total      <= '0;
            shortfall_events <= '0;
        end else begin
            if (ack_take && (coins_total != 16'hFFFF)) begin
                coins_total <= coins_total + 16'd1;
            end
            if (done && (shortfall != 8'd0) && (shortfall_events != 8'hFF)) begin
                shortfall_events <= shortfall_events + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a greedy payout model.
// Latency: n/a.
// Backpressure: exercises stalled coin_ack and ignored change_valid while busy.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  change_in;
    logic        change_valid;
    logic        change_ready;
    logic [7:0]  coin_out;
    logic        coin_valid;
    logic        coin_ack;
    logic        refill_valid;
    logic [2:0]  refill_idx;
    logic        busy;
    logic        done;
    logic [7:0]  shortfall;
`ifdef CHANGE_DISPENSER_STATS_EN
    logic [15:0] coins_total;
    logic [7:0]  shortfall_events;
`endif

    always #5 clk = ~clk;

    change_dispenser #(.INV_W(4), .INIT_COUNT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .change_in    (change_in),
        .change_valid (change_valid),
        .change_ready (change_ready),
        .coin_out     (coin_out),
        .coin_valid   (coin_valid),
        .coin_ack     (coin_ack),
        .refill_valid (refill_valid),
        .refill_idx   (refill_idx),
        .busy         (busy),
        .done         (done),
`ifdef CHANGE_DISPENSER_STATS_EN
        .coins_total      (coins_total),
        .shortfall_events (shortfall_events),
`endif
        .shortfall    (shortfall)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int VAL [5] = '{10, 20, 50, 100, 200};
    int m_inv [5];
    int exp_q [$];
    int exp_sf;
    int m_coins = 0;
    int m_sf_ev = 0;

    // Greedy plan of the whole payout; updates the model inventory.
    function automatic void plan_payout(input int amt);
        int rem;
        int pick;
        exp_q.delete();
        rem = amt;
        forever begin
            pick = -1;
            for (int i = 4; i >= 0; i--) begin
                if (pick < 0 && m_inv[i] > 0 && VAL[i] <= rem) pick = i;
            end
            if (rem == 0 || pick < 0) break;
            exp_q.push_back(pick);
            m_inv[pick] = m_inv[pick] - 1;
            rem = rem - VAL[pick];
        end
        exp_sf = rem;
    endfunction

    task automatic do_refill(input int idx);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_idx   = 3'(idx);
        if (idx < 5 && m_inv[idx] < 15) m_inv[idx] = m_inv[idx] + 1;
        @(negedge clk);
        refill_valid = 1'b0;
    endtask

    // One full payout: ack_mode 0 = always ack, 1 = random; stall = cycles to hold the first ack low;
    // refill0 = refill the 10s in every ack cycle; noise = drive change_valid/coin_ack when they must be ignored.
    task automatic run_payout(input int amt, input int ack_mode, input int stall, input bit refill0, input bit noise);
        int  last_ack;
        int  stall_left;
        int  ncoins;
        bit  got_done;
        bit  prev_vld;
        bit  ack;
        plan_payout(amt);
        ncoins     = exp_q.size();
        last_ack   = -1;
        stall_left = stall;
        got_done   = 1'b0;
        prev_vld   = 1'b0;
        @(negedge clk);
        checks++;
        if (change_ready !== 1'b1) begin
            errors++;
            $display("FAIL pay%0d_ready got %b want 1", amt, change_ready);
        end
        change_in    = 8'(amt);
        change_valid = 1'b1;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            coin_ack     = 1'b0;
            refill_valid = 1'b0;
            if (noise) begin
                change_valid = 1'b1;
                change_in    = 8'($urandom);
            end else begin
                change_valid = 1'b0;
            end
            if (done) begin
                got_done     = 1'b1;
                change_valid = 1'b0;
                checks++;
                if (shortfall !== 8'(exp_sf)) begin
                    errors++;
                    $display("FAIL pay%0d_shortfall got %0d want %0d", amt, shortfall, exp_sf);
                end
                checks++;
                if (coin_valid !== 1'b0 || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL pay%0d_done_clean coin_valid %b coins_left %0d want 0/0", amt, coin_valid, exp_q.size());
                end
                checks++;
                if (cyc != ((last_ack < 0) ? 1 : last_ack + 2)) begin
                    errors++;
                    $display("FAIL pay%0d_done_time got cycle %0d want %0d", amt, cyc, (last_ack < 0) ? 1 : last_ack + 2);
                end
            end else if (coin_valid) begin
                if (!prev_vld) begin
                    checks++;
                    if (cyc != ((last_ack < 0) ? 1 : last_ack + 2)) begin
                        errors++;
                        $display("FAIL pay%0d_coin_time got cycle %0d want %0d", amt, cyc, (last_ack < 0) ? 1 : last_ack + 2);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pay%0d_extra_coin got %0d want none", amt, coin_out);
                end else if (coin_out !== 8'(VAL[exp_q[0]])) begin
                    errors++;
                    $display("FAIL pay%0d_coin got %0d want %0d", amt, coin_out, VAL[exp_q[0]]);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    ack = 1'b0;
                end else begin
                    ack = (ack_mode == 0) ? 1'b1 : 1'($urandom % 2);
                end
                if (ack) begin
                    coin_ack = 1'b1;
                    last_ack = cyc;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    if (refill0) begin
                        refill_valid = 1'b1;
                        refill_idx   = 3'd0;
                        if (m_inv[0] < 15) m_inv[0] = m_inv[0] + 1;
                    end
                end
            end else begin
                checks++;
                if (coin_out !== 8'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL pay%0d_select coin_out %0d busy %b want 0/1", amt, coin_out, busy);
                end
                if (noise) coin_ack = 1'($urandom % 2);
            end
            prev_vld = coin_valid;
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL pay%0d_timeout no done within 300 cycles", amt);
        end
        coin_ack     = 1'b0;
        refill_valid = 1'b0;
        change_valid = 1'b0;
        m_coins = m_coins + ncoins;
        if (exp_sf != 0) m_sf_ev++;
        @(negedge clk);
        checks++;
        if (change_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL pay%0d_back_idle ready %b busy %b done %b want 1/0/0", amt, change_ready, busy, done);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (32'(dut.inv[i]) !== m_inv[i]) begin
                errors++;
                $display("FAIL pay%0d_inv%0d got %0d want %0d", amt, i, dut.inv[i], m_inv[i]);
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m_inv[i] = 8;
        m_coins = 0;
        m_sf_ev = 0;
        checks++;
        if (change_ready !== 1'b1 || coin_valid !== 1'b0 || coin_out !== 8'd0 ||
            busy !== 1'b0 || done !== 1'b0 || shortfall !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs ready %b vld %b coin %0d busy %b done %b sf %0d want 1/0/0/0/0/0",
                     change_ready, coin_valid, coin_out, busy, done, shortfall);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (32'(dut.inv[i]) !== 8) begin
                errors++;
                $display("FAIL reset_inv%0d got %0d want 8", i, dut.inv[i]);
            end
        end
    endtask

    task automatic test_basic;
        run_payout(170, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_drain_hundreds;
        for (int k = 0; k < 8; k++) run_payout(100, 0, 0, 1'b0, 1'b0);
        run_payout(170, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_odd_and_zero;
        run_payout(15, 0, 0, 1'b0, 1'b0);
        run_payout(0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        run_payout(30, 0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_refill;
        int guard;
        guard = 0;
        while (m_inv[0] > 1 && guard < 20) begin
            run_payout(10, 0, 0, 1'b0, 1'b0);
            guard++;
        end
        // Last 10 acknowledged in the same cycle as a refill of the 10s: count stays put.
        run_payout(10, 0, 0, 1'b1, 1'b0);
        run_payout(10, 0, 0, 1'b0, 1'b0);
        // 10s now empty; a refill must be usable by the next payout.
        do_refill(0);
        run_payout(10, 0, 0, 1'b0, 1'b0);
        // Out-of-range index must not touch inventory.
        do_refill(6);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (32'(dut.inv[i]) !== m_inv[i]) begin
                errors++;
                $display("FAIL refill_idx6_inv%0d got %0d want %0d", i, dut.inv[i], m_inv[i]);
            end
        end
        // Saturation at 15.
        for (int k = 0; k < 20; k++) do_refill(4);
        checks++;
        if (32'(dut.inv[4]) !== 15) begin
            errors++;
            $display("FAIL refill_saturate got %0d want 15", dut.inv[4]);
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 25; k++) begin
            if ($urandom % 3 == 0) do_refill(int'($urandom_range(0, 7)));
            run_payout(int'($urandom_range(0, 255)), 1, 0, 1'b0, 1'b1);
        end
    endtask

`ifdef CHANGE_DISPENSER_STATS_EN
    task automatic test_stats;
        @(negedge clk);
        checks++;
        if (32'(coins_total) !== m_coins || 32'(shortfall_events) !== m_sf_ev) begin
            errors++;
            $display("FAIL stats got coins %0d events %0d want %0d %0d", coins_total, shortfall_events, m_coins, m_sf_ev);
        end
    endtask
`endif

    task automatic test_reset_mid;
        bit seen;
        if (m_inv[4] == 0) do_refill(4);
        @(negedge clk);
        change_in    = 8'd200;
        change_valid = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            change_valid = 1'b0;
            if (coin_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || coin_out !== 8'd200) begin
            errors++;
            $display("FAIL rstmid_coin got vld %b coin %0d want 1/200", seen, coin_out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m_inv[i] = 8;
        m_coins = 0;
        m_sf_ev = 0;
        checks++;
        if (coin_valid !== 1'b0 || change_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs vld %b ready %b done %b busy %b want 0/1/0/0", coin_valid, change_ready, done, busy);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (32'(dut.inv[i]) !== 8) begin
                errors++;
                $display("FAIL rstmid_inv%0d got %0d want 8", i, dut.inv[i]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_done got %b want 0", done);
            end
        end
`ifdef CHANGE_DISPENSER_STATS_EN
        test_stats();
`endif
        run_payout(170, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        change_in    = 8'd0;
        change_valid = 1'b0;
        coin_ack     = 1'b0;
        refill_valid = 1'b0;
        refill_idx   = 3'd0;
        test_reset();
        test_basic();
        test_drain_hundreds();
        test_odd_and_zero();
        test_stall();
        test_refill();
        test_random();
`ifdef CHANGE_DISPENSER_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-payout engine for the vending machine's coin-return side. It takes a change amount from the vending controller through a valid/ready handshake and breaks it into physical coins (200, 100, 50, 20, 10) by greedy selection against a per-denomination coin inventory. Coins go one per handshake to the coin-ejector mechanism. Any amount that cannot be paid is reported as a shortfall.

## Interface
- INV_W, 4, width of each denomination's inventory counter (saturating)
- INIT_COUNT, 8, inventory loaded into every denomination at reset (must fit INV_W)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- change_in  input  8  change amount, unsigned, in the same units as the coin values
- change_valid  input  1  change_in is valid
- change_ready  output  1  high only in IDLE; a transfer occurs when change_valid and change_ready are both high at a rising edge
- coin_out  output  8  denomination currently being ejected; 0 when coin_valid is low
- coin_valid  output  1  coin_out is presented to the ejector
- coin_ack  input  1  ejector accepted the coin; sampled only while coin_valid is high
- refill_valid  input  1  add one coin to inventory
- refill_idx  input  3  denomination index 0..4 (10,20,50,100,200); values 5..7 are ignored
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse at the end of a payout
- shortfall  output  8  amount left unpaid, valid while done is high; holds until the next done

## Operation
- FSM states: IDLE, SELECT, DISPENSE, DONE.
- IDLE: change_ready=1. On a handshake, latch change_in into `remaining` and go to SELECT.
- SELECT: pick the largest denomination with inventory>0 and value<=`remaining`.
  - If one is found, register it into coin_out and go to DISPENSE.
  - If `remaining`==0 or no denomination fits, go to DONE.
- DISPENSE: coin_valid=1, with coin_out held stable. On coin_ack:
  - `remaining` -= coin_out
  - that denomination's inventory is decremented
  - go to SELECT.
- DONE: done=1 and shortfall=`remaining` for one cycle, then go to IDLE.
- Arithmetic: `remaining` is 8-bit unsigned. Subtraction cannot underflow because selection guarantees value<=`remaining`.
- Amounts that are not a multiple of 10 leave a remainder, which is reported as shortfall (e.g. 15 pays 10 and reports shortfall 5).
- change_in=0: the handshake is accepted, then SELECT, then DONE with shortfall 0 and no coins.
- Refill is accepted in any state.
  - The counter saturates at 2^INV_W-1.
  - If a refill and a dispense-decrement hit the same denomination in the same cycle, the count is unchanged.
  - A refill of a denomination that was empty becomes visible to the next SELECT.
- coin_ack while coin_valid is low is ignored. change_valid outside IDLE is ignored: no transfer, and the input is not latched.
- Reset mid-payout aborts it:
  - state returns to IDLE
  - `remaining` is cleared
  - every inventory reloads INIT_COUNT
  - no done pulse is generated.
- Reset values: change_ready=1 (first cycle after reset), coin_out=0, coin_valid=0, busy=0, done=0, shortfall=0.

## Timing
- Handshake at edge E0 → SELECT during cycle E0..E1 → coin_valid high from E1.
- First coin latency is 1 cycle after acceptance.
- coin_ack sampled at edge Ek → SELECT → next coin_valid from Ek+1. With coin_ack tied high, one coin is ejected every 2 cycles.
- After the final ack at edge Ek:
  - SELECT finds nothing and moves to DONE at Ek+1
  - done is high for the cycle Ek+1..Ek+2
  - change_ready goes high from Ek+2.
- coin_valid is never asserted in the same cycle as done.

## Configuration
- CHANGE_DISPENSER_STATS_EN defined: adds two output ports, each saturating and cleared only by rst.
  - coins_total [15:0]: count of acknowledged coins.
  - shortfall_events [7:0]: count of done pulses with nonzero shortfall.
- Not defined: those ports and their counters do not exist. All other behaviour is identical.

## Structure
- vending_pkg holds:
  - NUM_COINS=5
  - the coin value constant array indexed 0..4 = 10,20,50,100,200
  - the dispenser state enum
  - the coin-index typedef (3-bit).
- Sub-module coin_selector: purely combinational greedy pick.
  - Inputs: `remaining`, inventory-nonzero vector.
  - Outputs: found, idx.
  - Instantiated once and used in SELECT.

## Test plan
- Reset, then change_in=170 → coins 100, 50, 20 (ack each cycle); done with shortfall=0; inventories 100:7, 50:7, 20:7.
- Drain 100s (8 payouts of 100), then change_in=170 → coins 50, 50, 50, 20; shortfall=0.
- change_in=15 → single coin 10, done with shortfall=5; change_in=0 → no coin_valid, done at E1..E2 with shortfall=0.
- Hold coin_ack low for 5 cycles during the first coin of 30 → coin_out=20 stays stable with coin_valid high throughout; after the ack the next coin is 10.
- Empty the 10s, refill idx 0 in the same cycle that a 10-coin is acknowledged → count unchanged; refill_idx=6 → no inventory change.
- Assert rst during DISPENSE of a 200 payout → coin_valid=0 and change_ready=1 next cycle, no done pulse, all inventories=8; with CHANGE_DISPENSER_STATS_EN defined, coins_total=0.
